serializer_piso_msb: RTL and testbench

// - Parallel-in/serial-out stage directly upstream of the 11011 sequence detector.
// - Accepts a WIDTH-bit word through a valid/ready handshake.
// - Shifts the word out MSB-first, one bit per clk, on sout; sout drives the detector's din.
// - Supports gapless back-to-back words, so a pattern that spans a word boundary is still detected.

---
 rtl/serializer_piso_msb.sv | 101 ++++++++++
 tb/tb_serializer_piso_msb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serializer_piso_msb.sv
// MSB-first parallel-in/serial-out feeding the 11011 detector; gapless reload.
// Optional even-parity bit after the LSB when SER_PARITY_EN is defined.
module serializer_piso_msb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done
);

`ifdef SER_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [F-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          last;
  logic          accept;
  logic [F-1:0]  load_word;

  assign last   = (state == SHIFT) && (cnt == '0);
  assign accept = load_valid && load_ready;

`ifdef SER_PARITY_EN
  assign load_word = {data_in, ^data_in};
`else
  assign load_word = data_in;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next state: reload on the last bit keeps us in SHIFT
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = SHIFT;
      SHIFT: if (cnt == '0 && !accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: sout forced low outside frames
  always_comb begin
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    word_done  = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        sout       = shreg[F-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
        word_done  = last;
        load_ready = last;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // shift register and bit counter; cnt never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= load_word;
      cnt   <= CW'(F - 1);
    end else if (state == SHIFT && cnt != '0) begin
      shreg <= shreg << 1;
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_serializer_piso_msb.sv
// Directed table-driven bench for serializer_piso_msb at WIDTH=8.
// Frame expectations carry a hand-computed parity column used with SER_PARITY_EN.
module tb_serializer_piso_msb;

`ifdef SER_PARITY_EN
  localparam int F = 9;
`else
  localparam int F = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       word_done;

  int checks;
  int errors;

  serializer_piso_msb #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .word_done  (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [8:0] frame;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic e_sout,
                           input logic e_valid, input logic e_done,
                           input logic e_ready);
    chk({tag, " sout"}, sout, e_sout);
    chk({tag, " sout_valid"}, sout_valid, e_valid);
    chk({tag, " busy"}, busy, e_valid);
    chk({tag, " word_done"}, word_done, e_done);
    chk({tag, " load_ready"}, load_ready, e_ready);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] w,
                           input logic [8:0] fr);
    @(negedge clk);
    data_in    = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in    = 8'h00;
    for (int i = 0; i < F; i++) begin
      chk_cycle($sformatf("%s bit%0d", tag, i), fr[8-i], 1'b1,
                i == F - 1, i == F - 1);
      tick();
    end
    chk_cycle({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [8:0] fa;
    logic [8:0] fb;
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    data_in    = 8'h00;
    load_valid = 1'b0;

    vecs[0] = '{8'hD8, {8'hD8, 1'b0}};
    vecs[1] = '{8'hDB, {8'hDB, 1'b0}};
    vecs[2] = '{8'h07, {8'h07, 1'b1}};
    vecs[3] = '{8'hA5, {8'hA5, 1'b0}};
    vecs[4] = '{8'h80, {8'h80, 1'b1}};
    vecs[5] = '{8'h01, {8'h01, 1'b1}};

    #1;
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_cycle("post-reset idle", 1'b0, 1'b0, 1'b0, 1'b1);

    for (int v = 0; v < 6; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].frame);

    // back-to-back 1B then 6C, load_valid held across both words
    fa = {8'h1B, 1'b0};
    fb = {8'h6C, 1'b0};
    @(negedge clk);
    data_in    = 8'h1B;
    load_valid = 1'b1;
    tick();
    data_in = 8'h6C;
    for (int i = 0; i < 2 * F; i++) begin
      if (i < F)
        chk_cycle($sformatf("b2b bit%0d", i), fa[8-i], 1'b1,
                  i == F - 1, i == F - 1);
      else
        chk_cycle($sformatf("b2b bit%0d", i), fb[8-(i-F)], 1'b1,
                  i == 2 * F - 1, i == 2 * F - 1);
      tick();
      if (i == F - 1) begin
        load_valid = 1'b0;
        data_in    = 8'h00;
      end
    end
    chk_cycle("b2b idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // busy stall: FF requested in cycle 3 of a D8 frame
    fa = {8'hD8, 1'b0};
    fb = {8'hFF, 1'b0};
    @(negedge clk);
    data_in    = 8'hD8;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 2 * F; i++) begin
      if (i == 2) begin
        data_in    = 8'hFF;
        load_valid = 1'b1;
      end
      if (i < F)
        chk_cycle($sformatf("stall bit%0d", i), fa[8-i], 1'b1,
                  i == F - 1, i == F - 1);
      else
        chk_cycle($sformatf("stall bit%0d", i), fb[8-(i-F)], 1'b1,
                  i == 2 * F - 1, i == 2 * F - 1);
      tick();
      if (i == F - 1) begin
        load_valid = 1'b0;
        data_in    = 8'h00;
      end
    end
    chk_cycle("stall idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // mid-word reset in bit cycle 4 of DB
    fa = {8'hDB, 1'b0};
    @(negedge clk);
    data_in    = 8'hDB;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_cycle($sformatf("mrst bit%0d", i), fa[8-i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_cycle("mrst bit3", fa[5], 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_cycle("mrst async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < F; i++) begin
      tick();
      chk_cycle($sformatf("mrst quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    run_frame("after mrst", 8'hDB, {8'hDB, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
